// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Controller states: waiting for an operation, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH = 8;

  // Width of the bit counter for a given operand width (never below one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

  // Quotient reported for divide-by-zero and overflow.
  localparam logic [DIV_WIDTH-1:0] QUOT_ONES = '1;

endpackage

// File: rtl/div_sub_chain.sv
// Ripple trial subtractor: computes s - divisor as s + ~divisor + 1 over
// WIDTH+1 cells. With DIV_APPROX_SUB_EN defined, the APPROX_BITS lowest cells
// use the approximate full-adder cell (sum = x | (y ^ z), cout = z & (x | y)).
module div_sub_chain #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] diff,
  output logic             no_borrow
);

`ifdef DIV_APPROX_SUB_EN
  localparam int APPROX_EFF = (APPROX_BITS > WIDTH) ? WIDTH : APPROX_BITS;
`else
  // Approximate cells compiled out: every cell is an exact full adder.
  localparam int APPROX_EFF = 0 * APPROX_BITS;
`endif

  logic [WIDTH:0]   y;
  logic [WIDTH+1:0] c;

  // Invert the zero-extended divisor; the +1 enters as the chain carry-in.
  assign y    = ~{1'b0, divisor};
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    if (i < APPROX_EFF) begin : g_approx
      assign diff[i]  = s[i] | (y[i] ^ c[i]);
      assign c[i+1]   = c[i] & (s[i] | y[i]);
    end else begin : g_exact
      assign c[i+1] = (s[i] & y[i]) | (c[i] & (s[i] ^ y[i]));
      // The top cell only contributes its carry; its sum bit is never needed.
      if (i < WIDTH) begin : g_sum
        assign diff[i] = s[i] ^ y[i] ^ c[i];
      end
    end
  end

  assign no_borrow = c[WIDTH+1];

endmodule

// File: rtl/seq_restoring_div_8.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per cycle. Optional macro DIV_APPROX_SUB_EN swaps the low
// APPROX_BITS trial-subtractor cells for the approximate cell.
// Handshake: an input is taken on an edge with in_valid && in_ready; a result
// is released on an edge with out_valid && out_ready. Outputs are held
// stable while out_valid is high.
module seq_restoring_div_8
  import div_pkg::*;
#(
  parameter int WIDTH       = DIV_WIDTH,
  parameter int APPROX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0]   IN2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Quot,
  output logic [WIDTH-1:0]   Rem,
  output logic               div_zero,
  output logic               ovf
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] r_q, d_q, dvsr_q, quot_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q, ovf_q;

  logic [WIDTH-1:0] in_hi, in_lo;
  logic             in_zero, in_ovf;
  logic [WIDTH:0]   s;
  logic [WIDTH-1:0] t;
  logic             nb;

  assign in_hi   = IN1[2*WIDTH-1:WIDTH];
  assign in_lo   = IN1[WIDTH-1:0];
  assign in_zero = (IN2 == '0);
  assign in_ovf  = (in_hi >= IN2);

  // Partial remainder extended by the next dividend bit.
  assign s = {r_q, d_q[WIDTH-1]};

  div_sub_chain #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_sub (
    .s         (s),
    .divisor   (dvsr_q),
    .diff      (t),
    .no_borrow (nb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flagged operations finish at the accept edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = (in_zero || in_ovf) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      d_q    <= '0;
      dvsr_q <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvsr_q <= IN2;
            d_q    <= in_lo;
            cnt_q  <= CW'(WIDTH - 1);
            if (in_zero) begin
              dz_q   <= 1'b1;
              ovf_q  <= 1'b0;
              quot_q <= '1;
              r_q    <= in_lo;
            end else if (in_ovf) begin
              dz_q   <= 1'b0;
              ovf_q  <= 1'b1;
              quot_q <= '1;
              r_q    <= '0;
            end else begin
              dz_q   <= 1'b0;
              ovf_q  <= 1'b0;
              quot_q <= '0;
              r_q    <= in_hi;
            end
          end
        end
        CALC: begin
          r_q    <= nb ? t : s[WIDTH-1:0];
          quot_q <= {quot_q[WIDTH-2:0], nb};
          d_q    <= d_q << 1;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Quot      = quot_q;
  assign Rem       = r_q;
  assign div_zero  = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_restoring_div_8.sv
// Self-checking bench for seq_restoring_div_8: directed cases, handshake
// hold, mid-operation reset and randomized traffic against a reference model.
module tb_seq_restoring_div_8;

  localparam int W         = 8;
  localparam int TB_APPROX = 4;
  localparam int MAX_WAIT  = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] IN1 = '0;
  logic [W-1:0]   IN2 = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   Quot, Rem;
  logic           div_zero, ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results, packed as {div_zero, ovf, quot, rem}.
  logic [2*W+1:0] exp_q[$];

  seq_restoring_div_8 #(.WIDTH(W), .APPROX_BITS(TB_APPROX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN1       (IN1),
    .IN2       (IN2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Quot      (Quot),
    .Rem       (Rem),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic division; approximate build walks the
  // bit-accurate cell behaviour of the trial subtraction.
  function automatic logic [2*W+1:0] ref_div(input logic [2*W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] q16, r16;
    logic [W-1:0]   r, d, q;
    logic [W:0]     s9, y9, t9;
    logic           c, x, y;
    if (b == 0) return {1'b1, 1'b0, {W{1'b1}}, a[W-1:0]};
    if (a[2*W-1:W] >= b) return {1'b0, 1'b1, {W{1'b1}}, {W{1'b0}}};
`ifdef DIV_APPROX_SUB_EN
    r = a[2*W-1:W];
    d = a[W-1:0];
    q = '0;
    y9 = ~{1'b0, b};
    for (int step = 0; step < W; step++) begin
      s9 = {r, d[W-1]};
      c = 1'b1;
      t9 = '0;
      for (int i = 0; i <= W; i++) begin
        x = s9[i];
        y = y9[i];
        if (i < TB_APPROX) begin
          t9[i] = x | (y ^ c);
          c     = c & (x | y);
        end else begin
          t9[i] = x ^ y ^ c;
          c     = (x & y) | (c & (x ^ y));
        end
      end
      r = c ? t9[W-1:0] : s9[W-1:0];
      q = {q[W-2:0], c};
      d = d << 1;
    end
    q16 = {{W{1'b0}}, q};
    r16 = {{W{1'b0}}, r};
`else
    q16 = a / b;
    r16 = a % b;
`endif
    return {1'b0, 1'b0, q16[W-1:0], r16[W-1:0]};
  endfunction

  // Present one operation and wait for the accept edge.
  task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input logic [2*W+1:0] expv);
    int waited = 0;
    while (!in_ready && waited < MAX_WAIT) begin
      @(posedge clk); #1; waited++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    exp_q.push_back(expv);
    in_valid = 1'b1;
    IN1 = a;
    IN2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    IN1 = 16'($urandom);
    IN2 = 8'($urandom);
  endtask

  // Count edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk); #1; lat++;
    end
    check("out_valid_wait", {31'b0, out_valid}, 32'd1);
  endtask

  // Compare the held result against the scoreboard, then release it.
  task automatic collect(input int hold);
    logic [2*W+1:0] e;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("result", {14'b0, div_zero, ovf, Quot, Rem}, {14'b0, e});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Directed operation with a spec-derived expected tuple and latency.
  task automatic directed(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W+1:0] expv, input int exp_lat);
    int lat;
    logic [2*W+1:0] e;
    e = expv;
`ifdef DIV_APPROX_SUB_EN
    e = ref_div(a, b);
`endif
    start_op(a, b, e);
    wait_valid(lat);
    check(tag, lat, exp_lat);
    collect(0);
  endtask

  initial begin : main
    int lat;
    logic [W-1:0] qa, qb;
    logic [2*W-1:0] ra;
    logic [2*W+1:0] e;

    // Reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_quot_rem",  {16'b0, Quot, Rem}, 32'd0);
    check("reset_flags",     {30'b0, div_zero, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases: latency is edges after accept until out_valid.
    directed("lat_200_7",    16'd200,   8'd7,   {2'b00, 8'd28,  8'd4},    W);
    directed("lat_65025",    16'd65025, 8'd255, {2'b00, 8'd255, 8'd0},    W);
    directed("lat_divzero",  16'd1234,  8'd0,   {2'b10, 8'hFF,  8'hD2},   0);
    directed("lat_ovf",      16'h0900,  8'd8,   {2'b01, 8'hFF,  8'h00},   0);
    directed("lat_edge_hi",  16'h07FF,  8'd8,   {2'b00, 8'd255, 8'd7},    W);
    directed("lat_div1",     16'h00AB,  8'd1,   {2'b00, 8'hAB,  8'h00},   W);

    // Hold the result with out_ready low; an in_valid pulse must be ignored.
    e = {2'b00, 8'd10, 8'd0};
`ifdef DIV_APPROX_SUB_EN
    e = ref_div(16'd50, 8'd5);
`endif
    start_op(16'd50, 8'd5, e);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1;
        IN1 = 16'd999;
        IN2 = 8'd3;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_result", {14'b0, div_zero, ovf, Quot, Rem}, {14'b0, e});
      check("hold_busy",   {30'b0, out_valid, in_ready}, 32'd2);
    end
    collect(0);
    check("release_idle", {30'b0, out_valid, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("pulse_ignored", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of an operation discards it.
    start_op(16'h0123, 8'h50, ref_div(16'h0123, 8'h50));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midreset_hs",     {30'b0, out_valid, in_ready}, 32'd1);
    check("midreset_quot",   {16'b0, Quot, Rem}, 32'd0);
    check("midreset_flags",  {30'b0, div_zero, ovf}, 32'd0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("midreset_no_out", {31'b0, out_valid}, 32'd0);
    directed("after_reset", 16'd100, 8'd3, {2'b00, 8'd33, 8'd1}, W);

    // Round-trip corners and randomized traffic with random consumer stalls.
    foreach (qa[i]) begin end
    for (int n = 0; n < 320; n++) begin
      if (n < 4) begin
        qa = (n[0]) ? 8'd255 : 8'd1;
        qb = (n[1]) ? 8'd255 : 8'd1;
      end else begin
        qa = 8'($urandom_range(1, 255));
        qb = 8'($urandom_range(1, 255));
      end
      if (n < 4 || $urandom_range(0, 9) < 6) begin
        ra = 16'(qa) * 16'(qb);
        e = {2'b00, qa, 8'd0};
`ifdef DIV_APPROX_SUB_EN
        e = ref_div(ra, qb);
`endif
        start_op(ra, qb, e);
      end else begin
        ra = 16'($urandom);
        if ($urandom_range(0, 15) == 0) qb = 8'd0;
        start_op(ra, qb, ref_div(ra, qb));
      end
      wait_valid(lat);
      collect($urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
